// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_padder
// Purpose  : Front end of the SHA-256 core. Packs an incoming byte stream
//            into 512-bit blocks, appends the 0x80 marker, zero fill and the
//            64-bit big-endian message bit length, then hands each block to
//            the schedule/compression stage as sixteen 32-bit words.
// Ports    :
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   load_enable    in   input_data carries a message byte this cycle
//   input_complete in   end of message, starts padding
//   input_data     in   [7:0]  message byte
//   in_ready       out  a byte can be accepted this cycle
//   word_valid     out  word_data holds a block word
//   word_ready     in   downstream takes word_data this cycle
//   word_data      out  [31:0] block word, big-endian byte packing
//   word_index     out  [3:0]  position of word_data in the block
//   last_block     out  current block closes the message
//   msg_done       out  single-cycle pulse after the final W15 is taken
// Revision : 1.0  initial release
// ============================================================================
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_enable,
    input  logic        input_complete,
    input  logic [7:0]  input_data,
    output logic        in_ready,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic [3:0]  word_index,
    output logic        last_block,
    output logic        msg_done
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PAD2 = 2'd2
    } state_t;

    localparam logic [7:0] c_PAD_BYTE = 8'h80;
    localparam logic [5:0] c_LAST_LEN_PTR = 6'd55;
    localparam logic [5:0] c_LAST_BYTE = 6'd63;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_buf [16];
    logic [31:0]      w_buf_next [16];
    logic [5:0]       r_byte_ptr;
    logic [5:0]       w_byte_ptr_next;
    logic [LEN_W-1:0] r_bit_len;
    logic [LEN_W-1:0] w_bit_len_next;
    logic             r_complete_pending;
    logic             w_complete_pending_next;
    logic             r_pad_next;
    logic             w_pad_next_next;
    logic             r_last_block;
    logic             w_last_block_next;
    logic [3:0]       r_word_index;
    logic [3:0]       w_word_index_next;
    logic             r_msg_done;
    logic             w_msg_done_next;
    logic [63:0]      w_len64;

    assign word_index = r_word_index;
    assign last_block = r_last_block;
    assign msg_done   = r_msg_done;

    // Length field is always 64 bits wide; a narrower counter is zero-extended.
    always_comb begin
        w_len64 = '0;
        w_len64[LEN_W-1:0] = r_bit_len;
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, datapath next values and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next            = r_state;
        w_buf_next              = r_buf;
        w_byte_ptr_next         = r_byte_ptr;
        w_bit_len_next          = r_bit_len;
        w_complete_pending_next = r_complete_pending;
        w_pad_next_next         = r_pad_next;
        w_last_block_next       = r_last_block;
        w_word_index_next       = r_word_index;
        w_msg_done_next         = 1'b0;
        in_ready                = 1'b0;
        word_valid              = 1'b0;
        word_data               = 32'h0;

        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                // End-of-message wins over a simultaneous byte so the last
                // byte cannot be written twice when load_enable is left high.
                if (input_complete || r_complete_pending) begin
                    w_complete_pending_next = 1'b0;
                    for (int w = 0; w < 16; w++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (6'(4 * w + b) == r_byte_ptr) begin
                                w_buf_next[w][31-8*b -: 8] = c_PAD_BYTE;
                            end else if (6'(4 * w + b) > r_byte_ptr) begin
                                w_buf_next[w][31-8*b -: 8] = 8'h00;
                            end
                        end
                    end
                    if (r_byte_ptr <= c_LAST_LEN_PTR) begin
                        w_buf_next[14]    = w_len64[63:32];
                        w_buf_next[15]    = w_len64[31:0];
                        w_last_block_next = 1'b1;
                        w_pad_next_next   = 1'b0;
                    end else begin
                        // No room for the length: it goes in an extra block.
                        w_last_block_next = 1'b0;
                        w_pad_next_next   = 1'b1;
                    end
                    w_state_next = EMIT;
                end else if (load_enable) begin
                    for (int w = 0; w < 16; w++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (6'(4 * w + b) == r_byte_ptr) begin
                                w_buf_next[w][31-8*b -: 8] = input_data;
                            end
                        end
                    end
                    w_byte_ptr_next = r_byte_ptr + 6'd1;
                    w_bit_len_next  = r_bit_len + LEN_W'(8);
                    if (r_byte_ptr == c_LAST_BYTE) begin
                        w_last_block_next = 1'b0;
                        w_pad_next_next   = 1'b0;
                        w_state_next      = EMIT;
                    end
                end
            end

            EMIT: begin
                word_valid = 1'b1;
                word_data  = r_buf[r_word_index];
                if (input_complete) begin
                    w_complete_pending_next = 1'b1;
                end
                if (word_ready) begin
                    w_word_index_next = r_word_index + 4'd1;
                    if (r_word_index == 4'd15) begin
                        if (r_pad_next) begin
                            w_state_next = PAD2;
                        end else begin
                            for (int w = 0; w < 16; w++) begin
                                w_buf_next[w] = 32'h0;
                            end
                            w_byte_ptr_next   = 6'd0;
                            w_last_block_next = 1'b0;
                            if (r_last_block) begin
                                w_msg_done_next = 1'b1;
                                w_bit_len_next  = '0;
                            end
                            w_state_next = FILL;
                        end
                    end
                end
            end

            PAD2: begin
                if (input_complete) begin
                    w_complete_pending_next = 1'b1;
                end
                for (int w = 0; w < 16; w++) begin
                    w_buf_next[w] = 32'h0;
                end
                w_buf_next[14]    = w_len64[63:32];
                w_buf_next[15]    = w_len64[31:0];
                w_last_block_next = 1'b1;
                w_pad_next_next   = 1'b0;
                w_state_next      = EMIT;
            end

            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int w = 0; w < 16; w++) begin
                r_buf[w] <= 32'h0;
            end
            r_byte_ptr         <= 6'd0;
            r_bit_len          <= '0;
            r_complete_pending <= 1'b0;
            r_pad_next         <= 1'b0;
            r_last_block       <= 1'b0;
            r_word_index       <= 4'd0;
            r_msg_done         <= 1'b0;
        end else begin
            for (int w = 0; w < 16; w++) begin
                r_buf[w] <= w_buf_next[w];
            end
            r_byte_ptr         <= w_byte_ptr_next;
            r_bit_len          <= w_bit_len_next;
            r_complete_pending <= w_complete_pending_next;
            r_pad_next         <= w_pad_next_next;
            r_last_block       <= w_last_block_next;
            r_word_index       <= w_word_index_next;
            r_msg_done         <= w_msg_done_next;
        end
    end

endmodule
`default_nettype wire
